// File: rtl/memoria_pkg.sv
// Shared types and default sizing for the data-memory responder.
package memoria_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned ADDR_W_DEF   = 4;
  localparam int unsigned READ_LAT_DEF = 2;
  // Wide enough for the largest legal read latency (15)
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/memoria_array.sv
// Single-port storage: synchronous write, asynchronous read.
// MEM_ZERO_ON_RESET_EN adds an async clear of every word on i_rst_n low.
module memoria_array
  import memoria_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
`ifdef MEM_ZERO_ON_RESET_EN
  input  logic              i_rst_n,
`endif
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

`ifdef MEM_ZERO_ON_RESET_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end
`else
  // No reset: contents survive reset pulses
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end
`endif

  assign o_rd_data = r_mem[i_addr];

endmodule

// File: rtl/memoria_dados_resp.sv
// Data-memory responder: serves one read or write at a time and signals completion with a one-cycle ack.
// Build option MEM_ZERO_ON_RESET_EN clears the storage array on reset.
module memoria_dados_resp
  import memoria_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned READ_LAT = READ_LAT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd,
  input  logic              we,
  input  logic [ADDR_W-1:0] endMem,
  input  logic [DATA_W-1:0] dataInMem,
  output logic [DATA_W-1:0] dataOutMem,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  logic              r_ack;
  logic              r_busy;
  logic              r_err;

  logic              w_wr_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rd_data;

  // Writes commit only on the accept edge; the latched address serves the read in WAIT
  assign w_wr_en = (r_state == IDLE) && we && !rd;
  assign w_addr  = (r_state == IDLE) ? endMem : r_addr;

  memoria_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk     (clock),
`ifdef MEM_ZERO_ON_RESET_EN
    .i_rst_n   (reset_n),
`endif
    .i_wr_en   (w_wr_en),
    .i_addr    (w_addr),
    .i_wr_data (dataInMem),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (rd && we) begin
            r_err   <= 1'b1;
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RESP;
          end else if (we) begin
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RESP;
          end else if (rd) begin
            r_addr <= endMem;
            r_busy <= 1'b1;
            if (READ_LAT == 0) begin
              r_dout  <= w_rd_data;
              r_ack   <= 1'b1;
              r_state <= RESP;
            end else begin
              r_cnt   <= CNT_W'(READ_LAT - 1);
              r_state <= WAIT;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        WAIT: begin
          // Data is sampled from the array as WAIT ends
          if (r_cnt == '0) begin
            r_dout  <= w_rd_data;
            r_ack   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dataOutMem = r_dout;
  assign ack        = r_ack;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_memoria_dados_resp.sv
// Self-checking bench for memoria_dados_resp against an array-based reference model.
module tb_memoria_dados_resp;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned READ_LAT = 2;
  localparam int unsigned DEPTH    = 16;

  logic              clock;
  logic              reset_n;
  logic              rd;
  logic              we;
  logic [ADDR_W-1:0] endMem;
  logic [DATA_W-1:0] dataInMem;
  logic [DATA_W-1:0] dataOutMem;
  logic              ack;
  logic              busy;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mdl_mem [DEPTH];
  bit                mdl_known [DEPTH];
  logic [DATA_W-1:0] mdl_last_rd;
  bit                prev_chained;

  memoria_dados_resp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd         (rd),
    .we         (we),
    .endMem     (endMem),
    .dataInMem  (dataInMem),
    .dataOutMem (dataOutMem),
    .ack        (ack),
    .busy       (busy),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model reaction to a reset pulse
  task automatic model_reset();
    mdl_last_rd  = '0;
    prev_chained = 1'b0;
`ifdef MEM_ZERO_ON_RESET_EN
    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i]   = '0;
      mdl_known[i] = 1'b1;
    end
`endif
  endtask

  // Pulse reset between edges and check outputs clear asynchronously
  task automatic apply_reset(input string tag);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    rd = 1'b0;
    we = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || dataOutMem !== '0) begin
      errors++;
      $display("FAIL %s reset outputs got ack=%b busy=%b err=%b dout=%h want 0 0 0 00",
               tag, ack, busy, err, dataOutMem);
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One request/response; caller is at a negedge with the DUT idle or in its ack cycle (chained)
  task automatic access(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit chain, input string tag);
    int          lat;
    int          exp_lat;
    bit          busy_bad;
    logic [DATA_W-1:0] exp_dout;
    exp_lat  = (r && !w) ? int'(READ_LAT) + 1 : 1;
    if (prev_chained) exp_lat++;
    exp_dout = (r && !w) ? mdl_mem[a] : mdl_last_rd;
    rd = r; we = w; endMem = a; dataInMem = d;
    lat = 0;
    busy_bad = 1'b0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if (ack === 1'b1) break;
      if (lat > (prev_chained ? 1 : 0) && busy !== 1'b1) busy_bad = 1'b1;
    end
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL %s ack timeout after %0d cycles", tag, lat);
    end else begin
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s latency got %0d want %0d", tag, lat, exp_lat);
      end
      checks++;
      if (err !== (r && w)) begin
        errors++;
        $display("FAIL %s err got %b want %b", tag, err, (r && w));
      end
      checks++;
      if (dataOutMem !== exp_dout) begin
        errors++;
        $display("FAIL %s dataOutMem got %h want %h", tag, dataOutMem, exp_dout);
      end
      checks++;
      if (busy !== 1'b1 || busy_bad) begin
        errors++;
        $display("FAIL %s busy in flight got %b (gap=%b) want 1", tag, busy, busy_bad);
      end
    end
    if (w && !r) begin
      mdl_mem[a]   = d;
      mdl_known[a] = 1'b1;
    end
    if (r && !w) mdl_last_rd = mdl_mem[a];
    rd = 1'b0;
    we = 1'b0;
    prev_chained = chain;
    if (!chain) begin
      @(negedge clock);
      checks++;
      if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s after ack got ack=%b err=%b busy=%b want 0 0 0", tag, ack, err, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || dataOutMem !== '0) begin
      errors++;
      $display("FAIL power_on_reset got ack=%b busy=%b err=%b dout=%h want 0 0 0 00",
               ack, busy, err, dataOutMem);
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_write_read();
    access(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, "wr3");
    access(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, "rd3");
    checks++;
    if (dataOutMem !== 8'hA5) begin
      errors++;
      $display("FAIL rd3_const got %h want a5", dataOutMem);
    end
  endtask

  task automatic test_reset_midrun();
    apply_reset("reset_midrun");
  endtask

  task automatic test_wrap();
    access(1'b0, 1'b1, 4'd0,  8'h11, 1'b0, "wr0");
    access(1'b0, 1'b1, 4'd15, 8'hFF, 1'b0, "wr15");
    access(1'b1, 1'b0, 4'd0,  8'h00, 1'b0, "rd0");
    access(1'b1, 1'b0, 4'd15, 8'h00, 1'b0, "rd15");
    access(1'b1, 1'b0, 4'd3,  8'h00, 1'b0, "rd3_unchanged");
  endtask

  task automatic test_error();
    access(1'b0, 1'b1, 4'd5, 8'h5A, 1'b0, "wr5");
    access(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, "rd0_pre_err");
    access(1'b1, 1'b1, 4'd5, 8'h77, 1'b0, "err5");
    access(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, "rd5_after_err");
  endtask

  task automatic test_reset_in_wait();
    bit ack_seen;
    rd = 1'b1; endMem = 4'd15;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || ack !== 1'b0) begin
      errors++;
      $display("FAIL wait_state got busy=%b ack=%b want 1 0", busy, ack);
    end
    apply_reset("reset_in_wait");
    ack_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ack !== 1'b0) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen) begin
      errors++;
      $display("FAIL aborted_read ack got 1 want 0");
    end
    access(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, "rd_after_abort");
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, 4'd9, 8'hC3, 1'b1, "b2b_wr");
    access(1'b1, 1'b0, 4'd9, 8'h00, 1'b1, "b2b_rd");
    access(1'b0, 1'b1, 4'd9, 8'h3C, 1'b1, "b2b_wr2");
    access(1'b1, 1'b0, 4'd9, 8'h00, 1'b0, "b2b_rd2");
  endtask

  task automatic test_reset_retention();
    logic [DATA_W-1:0] exp_val;
`ifdef MEM_ZERO_ON_RESET_EN
    exp_val = 8'h00;
`else
    exp_val = 8'h3C;
`endif
    access(1'b0, 1'b1, 4'd7, 8'h3C, 1'b0, "wr7");
    apply_reset("reset_retention");
    access(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, "rd7_after_reset");
    checks++;
    if (dataOutMem !== exp_val) begin
      errors++;
      $display("FAIL retention got %h want %h", dataOutMem, exp_val);
    end
  endtask

  task automatic test_random();
    int unsigned op;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit chain;
    for (int n = 0; n < 40; n++) begin
      op    = $urandom_range(0, 9);
      a     = ADDR_W'($urandom_range(0, DEPTH - 1));
      d     = DATA_W'($urandom);
      chain = ($urandom_range(0, 2) == 0);
      if (op == 0) begin
        access(1'b1, 1'b1, a, d, chain, "rnd_err");
      end else if (op < 5 && mdl_known[a]) begin
        access(1'b1, 1'b0, a, d, chain, "rnd_rd");
      end else begin
        access(1'b0, 1'b1, a, d, chain, "rnd_wr");
      end
    end
    if (prev_chained) begin
      @(negedge clock);
      prev_chained = 1'b0;
    end
  endtask

  initial begin
    rd = 1'b0; we = 1'b0; endMem = '0; dataInMem = '0;
    prev_chained = 1'b0;
    mdl_last_rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i]   = '0;
      mdl_known[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_reset_midrun();
    test_wrap();
    test_error();
    test_reset_in_wait();
    test_back_to_back();
    test_reset_retention();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
